// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_carry_adder
// Purpose  : WIDTH-bit add/subtract with the carry resolved CHUNK bits per stage.
// Revision : 1.0
// ============================================================================
module pipelined_carry_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_width_check
      $error("pipelined_carry_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  // Index 0 is the entry register holding conditioned operands; index k+1
  // holds the result of resolving slice k.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  c_q;
  logic [WIDTH-1:0] a_q [STAGES+1];
  logic [WIDTH-1:0] b_q [STAGES+1];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [CHUNK:0]   part [STAGES];
  logic             advance;

  assign advance  = !(vld[STAGES] && !out_ready);
  assign in_ready = !reset && advance;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
      assign part[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_q[k]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      c_q <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      vld <= {vld[STAGES-1:0], in_valid};
      if (in_valid) begin
        a_q[0] <= in_a;
        b_q[0] <= in_sub ? ~in_b : in_b;
        c_q[0] <= in_sub | in_cin;
        s_q[0] <= '0;
      end
      // Empty slots leave their data registers untouched.
      for (int k = 0; k < STAGES; k++) begin
        if (vld[k]) begin
          a_q[k+1]                     <= a_q[k];
          b_q[k+1]                     <= b_q[k];
          s_q[k+1]                     <= s_q[k];
          s_q[k+1][k*CHUNK +: CHUNK]   <= part[k][CHUNK-1:0];
          c_q[k+1]                     <= part[k][CHUNK];
        end
      end
    end
  end

  assign out_valid = vld[STAGES];
  assign out_sum   = s_q[STAGES];
  assign out_cout  = c_q[STAGES];
  assign out_ovf   = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1]) &&
                     (s_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_carry_adder
// Purpose  : Directed and random checks of pipelined_carry_adder against an
//            arithmetic reference model and an in-order scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pipelined_carry_adder;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] sb_q [$];   // {ovf, cout, sum}

  pipelined_carry_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result, borrow, and signed range test.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    logic [32:0] u;
    logic [31:0] sum;
    logic        cout;
    if (sub) begin
      r    = sa - sb;
      sum  = a - b;
      cout = (a >= b);
    end else begin
      r    = sa + sb + longint'(cin);
      u    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      sum  = u[31:0];
      cout = u[32];
    end
    return {((r > SMAX) || (r < SMIN)), cout, sum};
  endfunction

  // One clock cycle: sample handshakes mid-cycle, score transfers, advance.
  task automatic step(output logic acc);
    logic        ofire, stall;
    logic [31:0] hs;
    logic        hc, ho;
    logic [33:0] exp;
    #4;
    acc   = in_valid && in_ready;
    ofire = out_valid && out_ready;
    stall = out_valid && !out_ready;
    hs = out_sum; hc = out_cout; ho = out_ovf;
    if (stall) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    if (ofire) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check("sb_sum", out_sum, exp[31:0]);
        check("sb_cout", {31'd0, out_cout}, {31'd0, exp[32]});
        check("sb_ovf", {31'd0, out_ovf}, {31'd0, exp[33]});
      end
    end
    if (acc) sb_q.push_back(model(in_a, in_b, in_cin, in_sub));
    @(posedge clk);
    #1;
    if (stall) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", out_sum, hs);
      check("hold_cout", {31'd0, out_cout}, {31'd0, hc});
      check("hold_ovf", {31'd0, out_ovf}, {31'd0, ho});
    end
  endtask

  task automatic do_reset();
    logic acc;
    reset = 1'b1;
    in_valid = 1'b0;
    step(acc);
    step(acc);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", out_sum, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    reset = 1'b0;
    sb_q.delete();
  endtask

  // Single beat with exact latency and the expected values written out.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic [31:0] esum, input logic ecout,
                          input logic eovf);
    logic acc;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    step(acc);
    check("dir_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(acc);
      check("dir_early_valid", {31'd0, out_valid}, 32'd0);
    end
    step(acc);
    check("dir_latency", {31'd0, out_valid}, 32'd1);
    check("dir_sum", out_sum, esum);
    check("dir_cout", {31'd0, out_cout}, {31'd0, ecout});
    check("dir_ovf", {31'd0, out_ovf}, {31'd0, eovf});
    step(acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    int   stall_left;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    do_reset();

    send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // 16 back-to-back random beats: output stream must be gap-free.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
      step(acc);
      check("tput_accept", {31'd0, acc}, 32'd1);
      if (i >= 4) check("tput_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step(acc);
      check("tput_tail_valid", {31'd0, out_valid}, 32'd1);
    end
    step(acc);
    check("tput_done_valid", {31'd0, out_valid}, 32'd0);
    check("tput_sb_empty", sb_q.size(), 32'd0);

    // Backpressure: one 3-cycle stall, then random out_ready.
    sent = 0;
    stall_left = 3;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
    for (int c = 0; c < 200 && (sent < 8 || sb_q.size() > 0); c++) begin
      in_valid = (sent < 8);
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (stall_left == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      step(acc);
      if (acc) begin
        sent++;
        in_a = $urandom; in_b = $urandom;
        in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 32'd8);
    check("bp_stall_seen", stall_left, 32'd0);
    check("bp_sb_empty", sb_q.size(), 32'd0);

    // Reset with beats in flight: none of them may emerge afterwards.
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0; in_sub = 1'b0;
    step(acc);
    in_a = 32'hDEAD_BEEF;
    step(acc);
    reset = 1'b1;
    in_a = 32'h0BAD_F00D;
    step(acc);
    check("mid_rst_no_accept", {31'd0, acc}, 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(acc);
      check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    send_one(32'hFFFF_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
    check("final_sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the single-bit full adder: adds or subtracts two WIDTH-bit operands plus carry-in.
- Carry propagates between CHUNK-bit slices, one slice per pipeline stage.
- valid/ready handshake on both sides; sustains one operation per cycle with full backpressure.
- Building block for datapath arithmetic where a single-cycle WIDTH-bit carry chain misses timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK, otherwise elaboration error.
- CHUNK, 8, bits resolved per stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add mode only)
- in_sub  input  1  1 = compute A - B, 0 = compute A + B + cin
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB (sub: 1 = no borrow)
- out_ovf  output  1  signed two's-complement overflow

Behaviour:
- One clock; reset is synchronous and active-high. While reset=1 at a rising edge, all stage valid bits clear, out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=0 during reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !reset && !(out_valid && !out_ready).
- Operand conditioning at entry:
  - Sub mode: B' = ~in_b, c0 = 1, and in_cin is ignored.
  - Add mode: B' = in_b, c0 = in_cin.
- Stage k (k = 0..STAGES-1) computes {c(k+1), s[k]} = A[k] + B'[k] + c(k), CHUNK-bit slices, and registers:
  - the partial sum so far;
  - c(k+1);
  - the untouched upper operand slices (skew registers);
  - the top-bit signs needed for overflow;
  - a valid bit.
- Latency: a beat accepted at edge N has out_valid=1 after edge N+STAGES (4 cycles default) if there is no stall.
- Throughput is 1 beat/cycle. Bubbles propagate as valid=0 slots. Stage registers update only when the pipeline advances.
- Stall: global. When out_valid && !out_ready, no stage register changes and in_ready=0. out_sum, out_cout and out_ovf hold stable until transfer.
- Pass-through: simultaneous output transfer and input accept in the same cycle is legal; the pipeline shifts by one.
- Results:
  - out_cout = c(STAGES).
  - out_ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]).
- Output data when out_valid=0 is don't-care to consumers but must not be X after reset. Only valid slots' data registers need updating.
- Reset mid-operation: all in-flight beats are discarded. No out_valid pulse occurs for them after reset deasserts.
- Wrap-around: modular 2^WIDTH result; no saturation.
- Order: strict FIFO; results emerge in acceptance order.
- Every emitted beat must satisfy: {out_cout, out_sum} == A + B' + c0 (WIDTH+1-bit). Bench asserts this against a scoreboard.

Test Plan:
- Add: a=0x0000_00FF, b=0x0000_0001, cin=0, out_ready=1 -> after 4 cycles out_sum=0x0000_0100, cout=0, ovf=0; carry crosses the chunk 0→1 boundary.
- Full carry chain: a=0xFFFF_FFFF, b=0, cin=1 -> out_sum=0x0000_0000, cout=1, ovf=0. Then a=0x7FFF_FFFF, b=1, cin=0 -> out_sum=0x8000_0000, ovf=1, cout=0.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> out_sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000, b=1, sub=1 -> out_sum=0x7FFF_FFFF, ovf=1, cout=1.
- Throughput/order: 16 back-to-back random beats, out_ready=1 -> out_valid continuous from cycle 4 for 16 cycles; all match the scoreboard in order.
- Backpressure: stream 8 beats; drop out_ready for 3 cycles when out_valid=1 -> in_ready=0 in those cycles, outputs held stable; no beat lost or duplicated; scoreboard passes.
- Reset mid-flight: accept 3 beats, assert reset 1 cycle at cycle 2 -> out_valid stays 0 until a new beat is accepted; that new beat emerges 4 cycles later with the correct sum.
